uart_hex_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_tx_byte.sv | 105 ++++++++++
 rtl/uart_hex_tx.sv | 122 ++++++++++++
 tb/tb_uart_hex_tx.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the debug hex UART transmitter:
// FSM state encoding, line-ending constants, nibble-to-ASCII mapping and baud divisor.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE
  } uart_state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // 0-9 map to '0'-'9'; 10-15 map to uppercase 'A'-'F' (0x41 - 10 = 0x37).
  function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
    logic [7:0] ch;
    if (nibble < 4'd10) ch = 8'h30 + {4'h0, nibble};
    else                ch = 8'h37 + {4'h0, nibble};
    return ch;
  endfunction

  function automatic int calc_divisor(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// One-byte 8N1 serializer with a valid/ready handshake. Owns the baud counter
// and the registered txd line; ready is also high in the last stop-bit cycle.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int DIVISOR = 434
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       txd
);

  localparam int BAUD_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIVISOR - 1);

  uart_state_t       state, state_next;
  logic [BAUD_W-1:0] baud_cnt, baud_next;
  logic [2:0]        bit_idx, bit_next;
  logic [7:0]        shreg, shreg_next;
  logic              txd_next;
  logic              bit_end;

  assign bit_end = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      txd      <= 1'b1;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      shreg    <= shreg_next;
      txd      <= txd_next;
    end
  end

  // Accepting a byte at the end of a stop bit lets characters run back-to-back.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt + 1'b1;
    bit_next   = bit_idx;
    shreg_next = shreg;
    txd_next   = txd;
    ready      = 1'b0;
    case (state)
      IDLE: begin
        baud_next = '0;
        ready     = 1'b1;
        txd_next  = 1'b1;
        if (valid) begin
          state_next = START;
          shreg_next = data;
          txd_next   = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = DATA;
          txd_next   = shreg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_next = '0;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
            txd_next   = 1'b1;
          end else begin
            bit_next   = bit_idx + 3'd1;
            shreg_next = {1'b0, shreg[7:1]};
            txd_next   = shreg[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          ready     = 1'b1;
          baud_next = '0;
          if (valid) begin
            state_next = START;
            shreg_next = data;
            txd_next   = 1'b0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        baud_next  = '0;
        txd_next   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/uart_hex_tx.sv
// Debug UART: prints a DATA_W-bit value as uppercase hex followed by CR LF.
// Optional UART_HEX_TX_CHANGE_TRIGGER_EN: a changed value_i also starts a message.
module uart_hex_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] value_i,
  input  logic              send_i,
  output logic              busy_o,
  output logic              txd_o
);

  localparam int DIVISOR = calc_divisor(CLK_HZ, BAUD);
  localparam int NCHARS  = DATA_W / 4;
  localparam int MSG_LEN = NCHARS + 2;
  localparam int CHAR_W  = $clog2(MSG_LEN);
  localparam logic [CHAR_W-1:0] LAST_CHAR = CHAR_W'(MSG_LEN - 1);

  uart_state_t       state, state_next;
  logic [CHAR_W-1:0] char_cnt, char_next;
  logic [DATA_W-1:0] value_q;
  logic              trigger;
  logic              accept;
  logic              tx_valid;
  logic              tx_ready;
  logic [7:0]        tx_data;

  // Character idx of the message: hex digits MSB-first, then CR, then LF.
  function automatic logic [7:0] char_at(input logic [CHAR_W-1:0] idx,
                                         input logic [DATA_W-1:0] val);
    logic [3:0] nib;
    logic [7:0] ch;
    nib = '0;
    for (int i = 0; i < NCHARS; i++) begin
      if (idx == CHAR_W'(i)) nib = val[(NCHARS-1-i)*4 +: 4];
    end
    if (idx == CHAR_W'(NCHARS))  ch = ASCII_CR;
    else if (idx == LAST_CHAR)   ch = ASCII_LF;
    else                         ch = hex_ascii(nib);
    return ch;
  endfunction

  assign accept = (state == IDLE) && trigger;

`ifdef UART_HEX_TX_CHANGE_TRIGGER_EN
  logic [DATA_W-1:0] last_sent;

  // Changes seen while busy are not lost: a still-differing value fires again in IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    last_sent <= '0;
    else if (accept) last_sent <= value_i;
  end

  assign trigger = send_i | (value_i != last_sent);
`else
  assign trigger = send_i;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      char_cnt <= '0;
      value_q  <= '0;
    end else begin
      state    <= state_next;
      char_cnt <= char_next;
      if (accept) value_q <= value_i;
    end
  end

  // DATA means a message is in flight; char_cnt is the character currently being serialized.
  always_comb begin
    state_next = state;
    char_next  = char_cnt;
    tx_valid   = 1'b0;
    tx_data    = char_at(char_cnt + 1'b1, value_q);
    case (state)
      IDLE: begin
        tx_data = char_at({CHAR_W{1'b0}}, value_i);
        if (trigger) begin
          tx_valid   = 1'b1;
          char_next  = '0;
          state_next = DATA;
        end
      end
      DATA: begin
        tx_valid = (char_cnt != LAST_CHAR);
        if (tx_ready) begin
          if (char_cnt == LAST_CHAR) state_next = DONE;
          else                       char_next  = char_cnt + 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
        char_next  = '0;
      end
      default: begin
        state_next = IDLE;
        char_next  = '0;
      end
    endcase
  end

  assign busy_o = (state != IDLE);

  uart_tx_byte #(
    .DIVISOR(DIVISOR)
  ) u_tx_byte (
    .clk    (clk),
    .reset_n(reset_n),
    .valid  (tx_valid),
    .data   (tx_data),
    .ready  (tx_ready),
    .txd    (txd_o)
  );

endmodule

// File: tb/tb_uart_hex_tx.sv
// Directed bench for uart_hex_tx at DIVISOR=10: decodes the line mid-bit and
// checks characters, framing, spacing, busy time, resets and the change trigger.
module tb_uart_hex_tx;

  localparam int CLK_HZ     = 1000;
  localparam int BAUD       = 100;
  localparam int DIV        = 10;
  localparam int MSG_CYCLES = 10 * 10 * DIV + 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        send_i = 1'b0;
  logic [31:0] value_i = '0;
  logic        busy_o;
  logic        txd_o;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_hex_tx #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD),
    .DATA_W(32)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .value_i(value_i),
    .send_i (send_i),
    .busy_o (busy_o),
    .txd_o  (txd_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("[TB] check %s", tag);
    end
  endtask

  // Call at a falling edge; returns at the falling edge after the accepting clock.
  task automatic applyStimulus(input logic [31:0] value, input logic send);
    value_i = value;
    send_i  = send;
    @(negedge clk);
    send_i = 1'b0;
  endtask

  task automatic watch_idle(input string tag, input int n);
    logic stayed;
    stayed = 1'b1;
    repeat (n) begin
      @(negedge clk);
      if (txd_o !== 1'b1 || busy_o !== 1'b0) stayed = 1'b0;
    end
    checkOutput(tag, 32'(stayed), 32'd1);
  endtask

  // mode 1: ignored send_i plus value change mid-message; mode 2: value steps 6 then 7.
  task automatic receive_line(input string hex, input int mode, output int base_cyc);
    logic [7:0] rx;
    logic [7:0] exp_ch;
    logic       start_bit;
    logic       stop_bit;
    int         guard;
    int         settle;
    base_cyc = cyc;
    for (int k = 0; k < 10; k++) begin
      guard = 0;
      while (txd_o !== 1'b0 && guard < 300) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 300) begin
        checkOutput($sformatf("start_bit_seen_char%0d", k), 32'(txd_o), 32'd0);
        return;
      end
      if (k == 0) base_cyc = cyc;
      else checkOutput($sformatf("char%0d_spacing", k), 32'(cyc - base_cyc), 32'(100 * k));
      settle = 5;
      if (mode == 1 && k == 3) begin
        value_i = 32'h1;
        send_i  = 1'b1;
        @(negedge clk);
        send_i  = 1'b0;
        value_i = 32'hDEADBEEF;
        settle  = 4;
      end
      if (mode == 1 && k == 9) value_i = 32'h0012ABCD;
      if (mode == 2 && k == 2) value_i = 32'd6;
      if (mode == 2 && k == 5) value_i = 32'd7;
      repeat (settle) @(negedge clk);
      start_bit = txd_o;
      for (int b = 0; b < 8; b++) begin
        repeat (DIV) @(negedge clk);
        rx[b] = txd_o;
      end
      repeat (DIV) @(negedge clk);
      stop_bit = txd_o;
      if (k < 8)       exp_ch = 8'(hex[k]);
      else if (k == 8) exp_ch = 8'h0D;
      else             exp_ch = 8'h0A;
      checkOutput($sformatf("char%0d_value", k), 32'(rx), 32'(exp_ch));
      checkOutput($sformatf("char%0d_frame", k), 32'({start_bit, stop_bit}), 32'd1);
    end
    guard = 0;
    while (busy_o !== 1'b0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("busy_cycles", 32'(cyc - base_cyc), 32'(MSG_CYCLES));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    $display("[TB] start");
    repeat (3) @(negedge clk);
    checkOutput("reset_txd", 32'(txd_o), 32'd1);
    checkOutput("reset_busy", 32'(busy_o), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle_txd", 32'(txd_o), 32'd1);
    checkOutput("idle_busy", 32'(busy_o), 32'd0);

`ifdef UART_HEX_TX_CHANGE_TRIGGER_EN
    value_i = 32'd5;
    receive_line("00000005", 2, base);
    receive_line("00000007", 0, base);
`else
    value_i = 32'd5;
    watch_idle("no_trigger_5", 300);
    value_i = 32'd6;
    watch_idle("no_trigger_6", 300);
    value_i = 32'd7;
`endif
    watch_idle("steady_value_idle", 300);

    applyStimulus(32'h0012ABCD, 1'b1);
    checkOutput("accept_busy", 32'(busy_o), 32'd1);
    checkOutput("accept_txd", 32'(txd_o), 32'd0);
    receive_line("0012ABCD", 1, base);

    applyStimulus(32'hFFFFFFFF, 1'b1);
    checkOutput("rearm_busy", 32'(busy_o), 32'd1);
    checkOutput("rearm_txd", 32'(txd_o), 32'd0);
    receive_line("FFFFFFFF", 0, base);

    applyStimulus(32'h0012ABCD, 1'b1);
    base = cyc;
    repeat (244) @(negedge clk);
    checkOutput("char2_bit3_before_reset", 32'(txd_o), 32'd0);
    checkOutput("busy_before_reset", 32'(busy_o), 32'd1);
    reset_n = 1'b0;
    value_i = '0;
    #1;
    checkOutput("async_reset_txd", 32'(txd_o), 32'd1);
    checkOutput("async_reset_busy", 32'(busy_o), 32'd0);
    #2;
    reset_n = 1'b1;
    watch_idle("post_reset_idle", 200);

    applyStimulus(32'h0012ABCD, 1'b1);
    checkOutput("fresh_accept_busy", 32'(busy_o), 32'd1);
    receive_line("0012ABCD", 0, base);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
